// File: rtl/riscv_div_iter_if.sv
// Handshake bundle for the iterative divider: operand request, result response, kill and busy.
interface riscv_div_iter_if #(
  parameter int WIDTH = 32
);
  logic             kill;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output kill, in_valid, op, dividend, divisor, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  kill, in_valid, op, dividend, divisor, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/riscv_div_iter.sv
// Iterative radix-2 restoring divider (DIVU/DIV/REMU/REM), WIDTH+2 edges latency, 2 for x/0 and overflow.
// One operation in flight; result held in DONE until out_ready, kill aborts from any state.
module riscv_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  riscv_div_iter_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

  typedef enum logic [2:0] {IDLE, PREP, DIV, FIX, DONE} state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] quot;
  logic [WIDTH:0]   rem;
  logic [CNT_W-1:0] cnt;
  logic             q_neg;
  logic             r_neg;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [WIDTH-1:0] result_q;

  logic             a_sign;
  logic             b_sign;
  logic             div_zero;
  logic             ovf;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign a_sign   = op_q[0] & a_q[WIDTH-1];
  assign b_sign   = op_q[0] & b_q[WIDTH-1];
  assign a_abs    = a_sign ? (~a_q + ONE) : a_q;
  assign b_abs    = b_sign ? (~b_q + ONE) : b_q;
  assign div_zero = (b_q == '0);
  assign ovf      = op_q[0] && (a_q == MIN_NEG) && (b_q == ALL_ONE);

  // The next dividend bit enters from the top of the quotient register as it shifts out.
  assign rem_sh   = {rem[WIDTH-1:0], quot[WIDTH-1]};
  assign rem_ge   = (rem_sh >= {1'b0, b_q});
  assign rem_diff = rem_sh - {1'b0, b_q};

  assign q_fix    = q_neg ? (~quot + ONE) : quot;
  assign r_fix    = r_neg ? (~rem[WIDTH-1:0] + ONE) : rem[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      quot        <= '0;
      rem         <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
    end else if (bus.kill) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_q       <= bus.op;
            a_q        <= bus.dividend;
            b_q        <= bus.divisor;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= PREP;
          end
        end
        PREP: begin
          // Special cases preload final values with no sign fix-up and pass straight through FIX.
          if (div_zero) begin
            quot  <= ALL_ONE;
            rem   <= {1'b0, a_q};
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            state <= FIX;
          end else if (ovf) begin
            quot  <= a_q;
            rem   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            state <= FIX;
          end else begin
            quot  <= a_abs;
            b_q   <= b_abs;
            rem   <= '0;
            q_neg <= a_sign ^ b_sign;
            r_neg <= a_sign;
            cnt   <= CNT_W'(WIDTH);
            state <= DIV;
          end
        end
        DIV: begin
          rem  <= rem_ge ? rem_diff : rem_sh;
          quot <= {quot[WIDTH-2:0], rem_ge};
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          result_q    <= op_q[1] ? r_fix : q_fix;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_riscv_div_iter.sv
// Bench for riscv_div_iter: 32-bit and 8-bit instances, directed cases plus randomized sweeps
// checked every cycle against an arithmetic model of the RISC-V M-extension divide rules.
module tb_riscv_div_iter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst32;
  logic rst8;

  riscv_div_iter_if #(.WIDTH(32)) b32 ();
  riscv_div_iter_if #(.WIDTH(8))  b8 ();

  riscv_div_iter #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst32), .bus(b32.slave));
  riscv_div_iter #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst8),  .bus(b8.slave));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] mask_of(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input int w);
    logic [63:0] m;
    m = mask_of(w);
    return ((b & m) == 64'd0) || (op[0] && ((a & m) == (64'd1 << (w - 1))) && ((b & m) == m));
  endfunction

  function automatic logic [63:0] model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input int w);
    logic [63:0] m, ua, ub, q, r;
    longint sa, sb;
    m  = mask_of(w);
    ua = a & m;
    ub = b & m;
    if (ub == 64'd0) begin
      q = m;
      r = ua;
    end else if (op[0]) begin
      sa = ua[w-1] ? $signed(ua | ~m) : $signed(ua);
      sb = ub[w-1] ? $signed(ub | ~m) : $signed(ub);
      q  = sa / sb;
      r  = sa % sb;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    return (op[1] ? r : q) & m;
  endfunction

  // ---------------- per-cycle monitor ----------------
  bit          pend      [2];
  bit          seen      [2];
  bit          ready_due [2];
  logic [63:0] exp_res   [2];
  int          acc       [2];
  int          exp_lat   [2];

  task automatic mon(input int k, input int w, input logic r, input logic kill, input logic iv, input logic ir,
                     input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input logic ov,
                     input logic ordy, input logic [63:0] res, input logic bsy);
    if (r) begin
      chk("reset out_valid", 64'(ov), 64'd0);
      chk("reset in_ready", 64'(ir), 64'd1);
      chk("reset busy", 64'(bsy), 64'd0);
      chk("reset result", res, 64'd0);
      pend[k] = 0; seen[k] = 0; ready_due[k] = 0;
      return;
    end
    chk("in_ready vs busy", 64'(ir), 64'(!bsy));
    if (ready_due[k]) begin
      chk("in_ready after transfer", 64'(ir), 64'd1);
      ready_due[k] = 0;
    end
    if (ov) begin
      if (!pend[k]) chk("unexpected out_valid", 64'(ov), 64'd0);
      else begin
        chk("result", res, exp_res[k]);
        if (!seen[k]) chk("latency", 64'(cyc - acc[k]), 64'(exp_lat[k]));
        chk("in_ready in DONE", 64'(ir), 64'd0);
      end
      seen[k] = 1;
      if (ordy && !kill) begin
        pend[k] = 0; seen[k] = 0; ready_due[k] = 1;
      end
    end else if (pend[k] && (cyc - acc[k] > exp_lat[k] + 2)) begin
      chk("out_valid timeout", 64'(ov), 64'd1);
      pend[k] = 0;
    end
    if (kill) begin
      pend[k] = 0; seen[k] = 0; ready_due[k] = 0;
    end
    if (iv && ir && !kill) begin
      pend[k]    = 1;
      seen[k]    = 0;
      acc[k]     = cyc + 1;
      exp_res[k] = model(op, a, b, w);
      exp_lat[k] = is_special(op, a, b, w) ? 2 : w + 2;
    end
  endtask

  always @(negedge clk) begin
    mon(0, 32, rst32, b32.kill, b32.in_valid, b32.in_ready, b32.op, 64'(b32.dividend), 64'(b32.divisor),
        b32.out_valid, b32.out_ready, 64'(b32.result), b32.busy);
    mon(1, 8, rst8, b8.kill, b8.in_valid, b8.in_ready, b8.op, 64'(b8.dividend), 64'(b8.divisor),
        b8.out_valid, b8.out_ready, 64'(b8.result), b8.busy);
  end

  // ---------------- driver helpers ----------------
  function automatic logic get_ir(input int k);
    return (k == 0) ? b32.in_ready : b8.in_ready;
  endfunction
  function automatic logic get_ov(input int k);
    return (k == 0) ? b32.out_valid : b8.out_valid;
  endfunction
  function automatic logic get_bsy(input int k);
    return (k == 0) ? b32.busy : b8.busy;
  endfunction
  function automatic logic [63:0] get_res(input int k);
    return (k == 0) ? 64'(b32.result) : 64'(b8.result);
  endfunction

  task automatic drive(input int k, input logic v, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    if (k == 0) begin
      b32.in_valid = v; b32.op = op; b32.dividend = a[31:0]; b32.divisor = b[31:0];
    end else begin
      b8.in_valid = v; b8.op = op; b8.dividend = a[7:0]; b8.divisor = b[7:0];
    end
  endtask

  task automatic set_ctl(input int k, input logic ordy, input logic kill);
    if (k == 0) begin
      b32.out_ready = ordy; b32.kill = kill;
    end else begin
      b8.out_ready = ordy; b8.kill = kill;
    end
  endtask

  task automatic wait_ready(input int k);
    int n = 0;
    while (!get_ir(k) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!get_ir(k)) chk("in_ready wait", 64'(get_ir(k)), 64'd1);
  endtask

  // Issue one op, scramble the operand inputs after acceptance, return result and edges-to-valid.
  task automatic run_op(input int k, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat);
    wait_ready(k);
    drive(k, 1'b1, op, a, b);
    @(posedge clk); #1;
    drive(k, 1'b0, 2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom});
    lat = 0;
    while (!get_ov(k) && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    res = get_res(k);
  endtask

  function automatic logic [63:0] pick(input int w);
    case ($urandom_range(0, 7))
      0:       return 64'd1 << (w - 1);
      1:       return mask_of(w);
      2:       return 64'($urandom_range(0, 3));
      default: return {$urandom, $urandom} & mask_of(w);
    endcase
  endfunction

  task automatic sweep(input int k, input int w, input int n_ops);
    for (int i = 0; i < n_ops; i++) begin
      int n;
      wait_ready(k);
      drive(k, 1'b1, 2'($urandom_range(0, 3)), pick(w), pick(w));
      @(posedge clk); #1;
      drive(k, 1'b0, 2'b00, {$urandom, $urandom}, {$urandom, $urandom});
      n = 0;
      while (n < 200) begin
        set_ctl(k, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        @(posedge clk); #1;
        set_ctl(k, 1'b1, 1'b0);
        n++;
        if (get_ir(k)) break;
      end
      if (!get_ir(k)) chk("sweep return to idle", 64'(get_ir(k)), 64'd1);
    end
  endtask

  typedef struct {
    int          k;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    int          lat;
  } vec_t;

  vec_t        dv [12];
  logic [63:0] res;
  logic [63:0] held;
  int          lat;

  initial begin
    #2_000_000;
    $display("FAIL global timeout");
    $fatal(1, "global timeout");
  end

  initial begin
    rst32 = 1'b1;
    rst8  = 1'b1;
    drive(0, 1'b0, 2'b00, 64'd0, 64'd0);
    drive(1, 1'b0, 2'b00, 64'd0, 64'd0);
    set_ctl(0, 1'b1, 1'b0);
    set_ctl(1, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst32 = 1'b0;
    rst8  = 1'b0;
    @(posedge clk); #1;

    dv[0]  = '{0, 2'b00, 64'd100,        64'd7,        64'd14,         34};
    dv[1]  = '{0, 2'b10, 64'd100,        64'd7,        64'd2,          34};
    dv[2]  = '{0, 2'b01, 64'hFFFFFF9C,   64'd7,        64'hFFFFFFF2,   34};
    dv[3]  = '{0, 2'b11, 64'hFFFFFF9C,   64'd7,        64'hFFFFFFFE,   34};
    dv[4]  = '{0, 2'b11, 64'd100,        64'hFFFFFFF9, 64'd2,          34};
    dv[5]  = '{0, 2'b00, 64'd5,          64'd0,        64'hFFFFFFFF,   2};
    dv[6]  = '{0, 2'b11, 64'd5,          64'd0,        64'd5,          2};
    dv[7]  = '{0, 2'b01, 64'h80000000,   64'hFFFFFFFF, 64'h80000000,   2};
    dv[8]  = '{0, 2'b11, 64'h80000000,   64'hFFFFFFFF, 64'd0,          2};
    dv[9]  = '{1, 2'b01, 64'h80,         64'hFF,       64'h80,         2};
    dv[10] = '{1, 2'b00, 64'd200,        64'd7,        64'd28,         10};
    dv[11] = '{1, 2'b11, 64'h9C,         64'd7,        64'hFE,         10};

    for (int i = 0; i < 12; i++) begin
      run_op(dv[i].k, dv[i].op, dv[i].a, dv[i].b, res, lat);
      chk($sformatf("directed[%0d] result", i), res, dv[i].r);
      chk($sformatf("directed[%0d] latency", i), 64'(lat), 64'(dv[i].lat));
    end

    // Back-pressure: result must hold while the consumer stalls.
    set_ctl(0, 1'b0, 1'b0);
    run_op(0, 2'b00, 64'd1000, 64'd10, held, lat);
    chk("bp result", held, 64'd100);
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp out_valid held", 64'(get_ov(0)), 64'd1);
      chk("bp result stable", get_res(0), held);
      chk("bp in_ready low", 64'(get_ir(0)), 64'd0);
    end
    set_ctl(0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("bp single transfer", 64'(get_ov(0)), 64'd0);
    chk("bp in_ready after", 64'(get_ir(0)), 64'd1);

    // Kill during the fifth DIV cycle.
    wait_ready(0);
    drive(0, 1'b1, 2'b00, 64'd12345, 64'd17);
    @(posedge clk); #1;
    drive(0, 1'b0, 2'b00, 64'd0, 64'd0);
    repeat (5) @(posedge clk);
    #1;
    set_ctl(0, 1'b1, 1'b1);
    @(posedge clk); #1;
    set_ctl(0, 1'b1, 1'b0);
    chk("kill busy", 64'(get_bsy(0)), 64'd0);
    chk("kill in_ready", 64'(get_ir(0)), 64'd1);
    chk("kill out_valid", 64'(get_ov(0)), 64'd0);
    repeat (40) @(posedge clk);
    #1;
    run_op(0, 2'b00, 64'd9, 64'd3, res, lat);
    chk("post-kill DIVU 9/3", res, 64'd3);
    chk("post-kill latency", 64'(lat), 64'd34);

    // Kill beats in_valid in IDLE.
    @(posedge clk); #1;
    set_ctl(0, 1'b1, 1'b1);
    drive(0, 1'b1, 2'b00, 64'd50, 64'd5);
    @(posedge clk); #1;
    set_ctl(0, 1'b1, 1'b0);
    drive(0, 1'b0, 2'b00, 64'd0, 64'd0);
    chk("idle kill no accept busy", 64'(get_bsy(0)), 64'd0);
    chk("idle kill no accept in_ready", 64'(get_ir(0)), 64'd1);

    // Asynchronous reset mid-DIV.
    wait_ready(0);
    drive(0, 1'b1, 2'b00, 64'hFFFF, 64'd3);
    @(posedge clk); #1;
    drive(0, 1'b0, 2'b00, 64'd0, 64'd0);
    repeat (8) @(posedge clk);
    #2;
    rst32 = 1'b1;
    #1;
    chk("async rst out_valid", 64'(get_ov(0)), 64'd0);
    chk("async rst in_ready", 64'(get_ir(0)), 64'd1);
    chk("async rst busy", 64'(get_bsy(0)), 64'd0);
    chk("async rst result", get_res(0), 64'd0);
    @(posedge clk); #1;
    rst32 = 1'b0;
    @(posedge clk); #1;

    sweep(1, 8, 2000);
    sweep(0, 32, 200);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
